// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin one DIGIT-wide slice per clock,
// LSB digit first, reusing a single DIGIT-bit full-subtractor chain.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;

    logic [BW-1:0]    base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_dig;
    logic [DIGIT:0]   br;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // Bit offset of the digit being processed; always < WIDTH so BW bits suffice.
    assign base  = BW'(cnt_reg) * BW'(DIGIT);
    assign a_dig = a_reg[base +: DIGIT];
    assign b_dig = b_reg[base +: DIGIT];
    assign last  = (cnt_reg == CW'(NDIG - 1));
    assign br[0] = borrow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            assign d_dig[gi]  = a_dig[gi] ^ b_dig[gi] ^ br[gi];
            assign br[gi + 1] = (~a_dig[gi] & b_dig[gi]) | (~(a_dig[gi] ^ b_dig[gi]) & br[gi]);
        end
    endgenerate

    always_comb begin
        res_next = res_reg;
        res_next[base +: DIGIT] = d_dig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            diff       <= '0;
            bout       <= 1'b0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= bin;
                        res_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                        busy       <= 1'b1;
                        ready      <= 1'b0;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
                RUN: begin
                    res_reg    <= res_next;
                    borrow_reg <= br[DIGIT];
                    cnt_reg    <= cnt_reg + CW'(1);
                    // Result flags are published only once the MSB digit is done.
                    if (last) begin
                        diff      <= res_next;
                        bout      <= br[DIGIT];
                        zero      <= ~|res_next;
                        ovf       <= br[DIGIT-1] ^ br[DIGIT];
                        state_reg <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end
endmodule
